// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Four-way round-robin arbiter steering a shared 4:1 data mux into
//            a one-entry registered output stage.
// Revision : 1.0  initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_ready
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] c_LAST_RST = 2'd3;

    state_t       r_state;
    logic [1:0]   r_last;
    logic [W-1:0] r_data;
    logic [1:0]   r_src;

    logic [1:0]   w_grant;
    logic [1:0]   w_idx;
    logic         w_any;
    logic         w_load;
    logic [W-1:0] w_mux;

    // Scan from farthest to nearest so the nearest valid index after r_last wins.
    always_comb begin
        w_grant = r_last;
        w_idx   = r_last;
        w_any   = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last + 2'(k);
            if (req_valid[w_idx]) begin
                w_grant = w_idx;
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        w_mux = d0;
        case (w_grant)
            2'd0: w_mux = d0;
            2'd1: w_mux = d1;
            2'd2: w_mux = d2;
            2'd3: w_mux = d3;
        endcase
    end

    // Reset gates the handshake so no requester sees its word taken during rst.
    assign w_load    = !rst && w_any && ((r_state == S_EMPTY) || out_ready);
    assign req_ready = w_load ? (4'b0001 << w_grant) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_last  <= c_LAST_RST;
            r_data  <= '0;
            r_src   <= 2'd0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_load) begin
                        r_state <= S_FULL;
                        r_data  <= w_mux;
                        r_src   <= w_grant;
                        r_last  <= w_grant;
                    end
                end
                S_FULL: begin
                    if (w_load) begin
                        r_data <= w_mux;
                        r_src  <= w_grant;
                        r_last <= w_grant;
                    end else if (out_ready) begin
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == S_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Vector-table and scoreboard bench for mux_rr_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_arbiter;

    typedef struct packed {
        logic       r;
        logic [3:0] rv;
        logic       o;
        logic [3:0] rdy;
    } vec_t;

    typedef struct packed {
        logic [3:0] data;
        logic [1:0] src;
    } word_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = 4'b0000;
    logic [3:0] d0 = 4'd5, d1 = 4'd6, d2 = 4'd7, d3 = 4'd8;
    logic [3:0] req_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_ready = 1'b0;

    int    total = 0;
    int    bad   = 0;
    word_t sb[$];
    vec_t  tbl[16];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic word_t expected_word(input logic [3:0] onehot);
        word_t w;
        w.src = 2'd0;
        for (int i = 0; i < 4; i++)
            if (onehot[i]) w.src = 2'(i);
        case (w.src)
            2'd0:    w.data = d0;
            2'd1:    w.data = d1;
            2'd2:    w.data = d2;
            default: w.data = d3;
        endcase
        return w;
    endfunction

    // One clock: drive at negedge, check the handshake, then check the register.
    task automatic cycle(input logic r, input logic [3:0] rv, input logic o,
                         input logic [3:0] exp_rdy, input string nm);
        @(negedge clk);
        rst       = r;
        req_valid = rv;
        out_ready = o;
        #1;
        chk({nm, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && o) void'(sb.pop_front());
            if (exp_rdy != 4'b0000) sb.push_back(expected_word(exp_rdy));
        end
        #1;
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk({nm, ".out_data"}, 32'(out_data), 32'(sb[0].data));
            chk({nm, ".out_src"},  32'(out_src),  32'(sb[0].src));
        end else if (r) begin
            chk({nm, ".rst_data"}, 32'(out_data), 32'd0);
            chk({nm, ".rst_src"},  32'(out_src),  32'd0);
        end
    endtask

    initial begin
        // Reset with requests then full contention, wrap-around and drain.
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000};
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0100};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b1000};
        tbl[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100};
        tbl[11] = '{1'b0, 4'b1010, 1'b1, 4'b1000};
        tbl[12] = '{1'b0, 4'b1010, 1'b1, 4'b0010};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[15] = '{1'b0, 4'b0001, 1'b0, 4'b0001};

        for (int i = 0; i < 16; i++)
            cycle(tbl[i].r, tbl[i].rv, tbl[i].o, tbl[i].rdy, $sformatf("vec%0d", i));
        cycle(1'b0, 4'b0000, 1'b1, 4'b0000, "drain0");

        // Single requester after a fresh reset.
        cycle(1'b1, 4'b1111, 1'b1, 4'b0000, "rst_single");
        d2 = 4'hA;
        cycle(1'b0, 4'b0100, 1'b1, 4'b0100, "single");
        cycle(1'b0, 4'b0000, 1'b1, 4'b0000, "single_drain");
        d2 = 4'd7;

        // Backpressure: hold C from requester 1, stall three cycles, then release.
        d1 = 4'hC;
        cycle(1'b0, 4'b0010, 1'b1, 4'b0010, "bp_load");
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'b1111, 1'b0, 4'b0000, $sformatf("bp_stall%0d", i));
        cycle(1'b0, 4'b1111, 1'b1, 4'b0100, "bp_release");

        // Reset mid-operation, then priority restarts from index 0.
        cycle(1'b1, 4'b1111, 1'b0, 4'b0000, "mid_rst");
        cycle(1'b0, 4'b1010, 1'b1, 4'b0010, "post_rst");
        cycle(1'b0, 4'b1111, 1'b1, 4'b0100, "post_rst2");
        cycle(1'b0, 4'b0000, 1'b1, 4'b0000, "final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
